// File: rtl/afe_udma_subch_arbiter_if.sv
// Sub-channel sample side plus uDMA write side of the AFE sub-channel arbiter.
// slave is the arbiter's view. master is the view of the surrounding logic.
interface afe_udma_subch_arbiter_if #(
  parameter int NCH            = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int SUBCH_ID_WIDTH = 2
);
  logic [NCH-1:0]            cfg_ch_en_i;
  logic                      cfg_clr_i;
  logic [NCH-1:0]            ch_valid_i;
  logic [NCH*DATA_WIDTH-1:0] ch_data_i;
  logic [NCH-1:0]            ch_ready_o;
  logic                      udma_valid_o;
  logic [DATA_WIDTH-1:0]     udma_data_o;
  logic [SUBCH_ID_WIDTH-1:0] udma_subch_id_o;
  logic                      udma_ready_i;
  logic                      udma_vtransfer_o;
  logic [SUBCH_ID_WIDTH-1:0] udma_vtransfer_id_o;
  logic                      busy_o;

  modport slave (
    input  cfg_ch_en_i, cfg_clr_i, ch_valid_i, ch_data_i, udma_ready_i,
    output ch_ready_o, udma_valid_o, udma_data_o, udma_subch_id_o,
           udma_vtransfer_o, udma_vtransfer_id_o, busy_o
  );

  modport master (
    output cfg_ch_en_i, cfg_clr_i, ch_valid_i, ch_data_i, udma_ready_i,
    input  ch_ready_o, udma_valid_o, udma_data_o, udma_subch_id_o,
           udma_vtransfer_o, udma_vtransfer_id_o, busy_o
  );
endinterface

// File: rtl/afe_udma_subch_arbiter.sv
// Round-robin arbiter of NCH sub-channel sample streams into one uDMA beat register.
// Latency is 1 cycle from input handshake to output valid. A pop and a load in the same cycle keep full rate, and no sub-channel is granted while the held beat is stalled.
module afe_udma_subch_arbiter #(
  parameter int NCH            = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int SUBCH_ID_WIDTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  afe_udma_subch_arbiter_if.slave bus
);

  if (NCH < 2 || NCH > 16) begin : g_bad_nch
    $error("afe_udma_subch_arbiter: NCH must be within 2..16");
  end
  if (SUBCH_ID_WIDTH < $clog2(NCH)) begin : g_bad_id_width
    $error("afe_udma_subch_arbiter: SUBCH_ID_WIDTH too narrow for NCH");
  end

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  localparam logic [SUBCH_ID_WIDTH-1:0] PTR_RST = SUBCH_ID_WIDTH'(NCH - 1);

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [SUBCH_ID_WIDTH-1:0] id_q, id_d;
  logic [SUBCH_ID_WIDTH-1:0] ptr_q, ptr_d;

  logic [NCH-1:0]            elig;
  logic [NCH-1:0]            grant;
  logic [SUBCH_ID_WIDTH-1:0] grant_id;
  logic [DATA_WIDTH-1:0]     grant_data;
  logic                      found;
  logic                      pop;
  logic                      load_en;
  logic                      load;

  assign elig = bus.ch_valid_i & bus.cfg_ch_en_i;

  // Search ptr+1, ptr+2, ... modulo NCH, so the last winner becomes the lowest priority.
  always_comb begin
    grant      = '0;
    grant_id   = '0;
    grant_data = '0;
    found      = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!found && elig[k] && (k == ((int'(ptr_q) + i) % NCH))) begin
          found      = 1'b1;
          grant[k]   = 1'b1;
          grant_id   = SUBCH_ID_WIDTH'(k);
          grant_data = bus.ch_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    pop     = (state_q == ST_FULL) && bus.udma_ready_i;
    load_en = !bus.cfg_clr_i && ((state_q == ST_EMPTY) || pop);
    load    = load_en && found;

    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;

    case (state_q)
      ST_EMPTY: begin
        if (load) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (bus.cfg_clr_i)   state_d = ST_EMPTY;
        else if (pop && !load) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase

    if (bus.cfg_clr_i) begin
      ptr_d = PTR_RST;
    end else if (load) begin
      data_d = grant_data;
      id_d   = grant_id;
      ptr_d  = grant_id;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  // Reset gates ready directly, because the empty slot would otherwise offer a grant during reset.
  assign bus.ch_ready_o          = (load_en && !rst_i) ? grant : '0;
  assign bus.udma_valid_o        = (state_q == ST_FULL);
  assign bus.udma_data_o         = data_q;
  assign bus.udma_subch_id_o     = id_q;
  assign bus.udma_vtransfer_o    = pop && !bus.cfg_clr_i;
  assign bus.udma_vtransfer_id_o = id_q;
  assign bus.busy_o              = (state_q == ST_FULL);

endmodule

// File: tb/tb_afe_udma_subch_arbiter.sv
// Directed bench for afe_udma_subch_arbiter with NCH=4 and 32-bit samples.
module tb_afe_udma_subch_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cnt [NCH];

  afe_udma_subch_arbiter_if #(.NCH(NCH), .DATA_WIDTH(DW), .SUBCH_ID_WIDTH(IDW)) bus ();

  afe_udma_subch_arbiter #(.NCH(NCH), .DATA_WIDTH(DW), .SUBCH_ID_WIDTH(IDW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    bus.ch_data_i[k*DW +: DW] = v;
  endtask

  task automatic set_default_data();
    for (int k = 0; k < NCH; k++) set_data(k, 32'hD0D0_0000 + k);
  endtask

  initial begin
    // Reset state, with requests present to show ready is held low
    rst = 1'b1;
    bus.cfg_ch_en_i  = 4'hF;
    bus.ch_valid_i   = 4'hF;
    bus.cfg_clr_i    = 1'b0;
    bus.udma_ready_i = 1'b0;
    bus.ch_data_i    = '0;
    #1;
    chk("rst_valid", bus.udma_valid_o, 0);
    chk("rst_data", bus.udma_data_o, 0);
    chk("rst_id", bus.udma_subch_id_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_vtr", bus.udma_vtransfer_o, 0);
    chk("rst_ready", bus.ch_ready_o, 0);
    tick();
    rst = 1'b0;
    bus.cfg_ch_en_i = 4'h0;
    bus.ch_valid_i  = 4'h0;

    // Single requester on ch2, four back-to-back beats
    bus.cfg_ch_en_i  = 4'b0100;
    bus.ch_valid_i   = 4'b0100;
    bus.udma_ready_i = 1'b1;
    set_data(2, 32'hA5A5_0001);
    settle();
    chk("single_ready0", bus.ch_ready_o, 4'b0100);
    chk("single_valid0", bus.udma_valid_o, 0);
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk("single_valid", bus.udma_valid_o, 1);
      chk("single_data", bus.udma_data_o, 32'hA5A5_0000 + n);
      chk("single_id", bus.udma_subch_id_o, 2);
      chk("single_vtr", bus.udma_vtransfer_o, 1);
      chk("single_vtr_id", bus.udma_vtransfer_id_o, 2);
      if (n < 4) set_data(2, 32'hA5A5_0000 + n + 1);
      else bus.ch_valid_i = 4'b0000;
    end
    tick();
    chk("single_drain_valid", bus.udma_valid_o, 0);
    chk("single_drain_busy", bus.busy_o, 0);

    // Fairness: clear the pointer, then all four request continuously
    set_default_data();
    bus.cfg_ch_en_i = 4'hF;
    bus.ch_valid_i  = 4'hF;
    bus.cfg_clr_i   = 1'b1;
    settle();
    chk("fair_clr_ready", bus.ch_ready_o, 0);
    tick();
    bus.cfg_clr_i = 1'b0;
    settle();
    chk("fair_first_ready", bus.ch_ready_o, 4'b0001);
    for (int k = 0; k < NCH; k++) cnt[k] = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      chk("fair_id", bus.udma_subch_id_o, i % 4);
      if (bus.udma_vtransfer_o) cnt[bus.udma_vtransfer_id_o] = cnt[bus.udma_vtransfer_id_o] + 1;
    end
    for (int k = 0; k < NCH; k++) chk("fair_count", cnt[k], 100);
    bus.ch_valid_i = 4'h0;
    tick();
    chk("fair_drain_busy", bus.busy_o, 0);

    // Backpressure: hold ch1 beat 0x1234 for five cycles
    bus.udma_ready_i = 1'b0;
    bus.ch_valid_i   = 4'b0010;
    set_data(1, 32'h0000_1234);
    settle();
    chk("bp_load_ready", bus.ch_ready_o, 4'b0010);
    tick();
    bus.ch_valid_i = 4'hF;
    set_data(1, 32'hD0D0_0001);
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("bp_data", bus.udma_data_o, 32'h0000_1234);
      chk("bp_id", bus.udma_subch_id_o, 1);
      chk("bp_ready", bus.ch_ready_o, 0);
      chk("bp_vtr", bus.udma_vtransfer_o, 0);
      chk("bp_busy", bus.busy_o, 1);
      tick();
    end
    bus.udma_ready_i = 1'b1;
    settle();
    chk("bp_release_vtr", bus.udma_vtransfer_o, 1);
    chk("bp_release_vtr_id", bus.udma_vtransfer_id_o, 1);
    chk("bp_next_ready", bus.ch_ready_o, 4'b0100);
    tick();
    chk("bp_next_id", bus.udma_subch_id_o, 2);
    chk("bp_next_data", bus.udma_data_o, 32'hD0D0_0002);
    bus.ch_valid_i = 4'h0;
    tick();
    chk("bp_drain_busy", bus.busy_o, 0);

    // Enable masking, then drop ch0 enable while its beat is held
    bus.udma_ready_i = 1'b0;
    bus.cfg_ch_en_i  = 4'b0111;
    bus.ch_valid_i   = 4'b1001;
    settle();
    chk("mask_ready", bus.ch_ready_o, 4'b0001);
    tick();
    chk("mask_id", bus.udma_subch_id_o, 0);
    chk("mask_data", bus.udma_data_o, 32'hD0D0_0000);
    bus.cfg_ch_en_i = 4'b0110;
    settle();
    chk("mask_hold_ready", bus.ch_ready_o, 0);
    bus.udma_ready_i = 1'b1;
    settle();
    chk("mask_vtr", bus.udma_vtransfer_o, 1);
    chk("mask_vtr_id", bus.udma_vtransfer_id_o, 0);
    chk("mask_no_grant", bus.ch_ready_o, 0);
    tick();
    chk("mask_drain_valid", bus.udma_valid_o, 0);

    // Clear with simultaneous pop
    bus.udma_ready_i = 1'b0;
    bus.cfg_ch_en_i  = 4'hF;
    bus.ch_valid_i   = 4'hF;
    tick();
    chk("clr_loaded_id", bus.udma_subch_id_o, 1);
    bus.udma_ready_i = 1'b1;
    bus.cfg_clr_i    = 1'b1;
    settle();
    chk("clr_vtr", bus.udma_vtransfer_o, 0);
    chk("clr_ready", bus.ch_ready_o, 0);
    tick();
    chk("clr_busy", bus.busy_o, 0);
    chk("clr_valid", bus.udma_valid_o, 0);
    bus.cfg_clr_i = 1'b0;
    settle();
    chk("clr_next_ready", bus.ch_ready_o, 4'b0001);
    tick();
    chk("clr_next_id", bus.udma_subch_id_o, 0);

    // Asynchronous reset between edges while full
    bus.udma_ready_i = 1'b0;
    settle();
    chk("arst_pre_busy", bus.busy_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.udma_valid_o, 0);
    chk("arst_busy", bus.busy_o, 0);
    chk("arst_ready", bus.ch_ready_o, 0);
    chk("arst_vtr", bus.udma_vtransfer_o, 0);
    #2;
    rst = 1'b0;
    settle();
    chk("arst_first_ready", bus.ch_ready_o, 4'b0001);
    tick();
    chk("arst_first_id", bus.udma_subch_id_o, 0);
    chk("arst_first_valid", bus.udma_valid_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
